// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//
// Operand sequencer and result capture wrapped around an external 32x32
// radix-4 Booth multiplier.
//
//   * Operand pairs (a, b, tag) arrive on a valid/ready stream. They are held
//     in a small FIFO until the multiplier can take them.
//   * One pair at a time is offered to the multiplier. After the handshake the
//     sequencer waits for the multiplier's ready to drop and then rise again.
//     The rising ready marks the result on mul_r as valid.
//   * The 64-bit product is returned with its tag on a valid/ready output
//     stream. The output register holds its value while the consumer stalls.
//   * The sequencer drives the multiplier's synchronous reset. A watchdog
//     aborts an operation that never completes, sets a sticky error flag and
//     re-resets the multiplier.
//
// Ports
//   clk           rising-edge clock
//   async_rst_n   asynchronous active-low reset
//   in_valid      operand pair valid
//   in_ready      FIFO can accept (not full, not holding multiplier reset)
//   in_a, in_b    signed operands
//   in_tag        user tag, returned with the product
//   out_valid     product valid
//   out_ready     consumer accepts product
//   out_r         signed 64-bit product, taken verbatim from mul_r
//   out_tag       tag belonging to out_r
//   err           sticky watchdog flag, cleared only by async_rst_n
//   mul_sync_rst  synchronous reset to the multiplier
//   mul_valid     operand valid to the multiplier (high only while issuing)
//   mul_a, mul_b  operands to the multiplier (head of FIFO)
//   mul_ready     ready / done from the multiplier
//   mul_r         product from the multiplier
// ---------------------------------------------------------------------------
module booth_mul_seq #(
    parameter int DEPTH      = 4,   // FIFO entries, power of two, >= 2
    parameter int TAG_W      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 32   // must exceed the multiplier's 17-cycle busy time
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             err,
    output logic             mul_sync_rst,
    output logic             mul_valid,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_ready,
    input  logic [63:0]      mul_r
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      b;
        logic [31:0]      a;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TAG_W-1:0]   tag_q, tag_d;          // tag of the operation in the multiplier
    logic               seen_low_q, seen_low_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_r_q, out_r_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               err_q, err_d;

    entry_t             mem [DEPTH];
    entry_t             head;

    logic               push;
    logic               pop;
    logic               capture;
    logic               out_free;
    logic               fifo_full;

    // ------------------------------------------------------------------
    // Operand FIFO storage. Contents are not reset: the pointers define
    // what is valid, so discarding the FIFO only needs the pointers cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_tag, in_b, in_a};
        end
    end

    assign head      = mem[rd_ptr_q];
    assign fifo_full = (count_q == CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Interface outputs that are pure decodes of registered state
    // ------------------------------------------------------------------
    assign in_ready     = !fifo_full && (state_q != ST_RST_HOLD);
    assign mul_valid    = (state_q == ST_ISSUE);
    assign mul_sync_rst = (state_q == ST_RST_HOLD);
    assign mul_a        = head.a;
    assign mul_b        = head.b;
    assign out_valid    = out_valid_q;
    assign out_r        = out_r_q;
    assign out_tag      = out_tag_q;
    assign err          = err_q;

    assign push     = in_valid && in_ready;
    // The output register can take a new product if it is empty or if its
    // current product leaves on this edge.
    assign out_free = !out_valid_q || out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        seen_low_d = seen_low_q;
        wd_cnt_d   = wd_cnt_q;
        rst_cnt_d  = '0;
        err_d      = err_q;
        pop        = 1'b0;
        capture    = 1'b0;

        unique case (state_q)
            ST_RST_HOLD: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end

            ST_IDLE: begin
                // An operand pushed on this edge is visible at the FIFO head
                // next cycle, so issue can start immediately.
                if ((count_q != '0) || push) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (mul_ready) begin
                    pop        = 1'b1;
                    tag_d      = head.tag;
                    seen_low_d = 1'b0;
                    wd_cnt_d   = '0;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // The multiplier is still showing ready for the cycle(s)
                // right after the load; completion only counts once ready has
                // been observed low.
                if (!mul_ready) begin
                    seen_low_d = 1'b1;
                end
                if (mul_ready && seen_low_q) begin
                    if (out_free) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    // Abandon the operation: it produces no output, queued
                    // operands and the output register are untouched.
                    err_d   = 1'b1;
                    state_d = ST_RST_HOLD;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end

            ST_DRAIN: begin
                // mul_r is stable here: the multiplier is idle and mul_valid
                // is low, so the result can be captured whenever room appears.
                if (out_free) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Output register: a capture on the same edge as a consumer take keeps
    // out_valid high with the new product.
    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_tag_d   = out_tag_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_r_d     = mul_r;
            out_tag_d   = tag_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= ST_RST_HOLD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_q       <= '0;
            seen_low_q  <= 1'b0;
            wd_cnt_q    <= '0;
            rst_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_q       <= tag_d;
            seen_low_q  <= seen_low_d;
            wd_cnt_q    <= wd_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

endmodule
